// File: rtl/key_loader.sv
// Streams a KEY_W-bit locking key in CHUNK_W-bit pieces and commits it only after a clean load.
// Optional in_par even-parity check is compiled in with `define KEY_LOADER_PARITY_EN.
module key_loader #(
   parameter int KEY_W   = 255,
   parameter int CHUNK_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CHUNK_W-1:0] in_data,
   input  logic               in_last,
`ifdef KEY_LOADER_PARITY_EN
   input  logic               in_par,
`endif
   input  logic               clear,
   output logic [KEY_W-1:0]   locking_key,
   output logic               key_valid,
   output logic               load_err
);

   localparam int NCHUNK = (KEY_W + CHUNK_W - 1) / CHUNK_W;
   localparam int PAD    = NCHUNK * CHUNK_W - KEY_W;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int LO_W   = (NCHUNK - 1) * CHUNK_W;
   localparam int HI_W   = CHUNK_W - PAD;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [LO_W-1:0]   r_shadow;
   logic [KEY_W-1:0]  r_key;
   logic              r_key_valid;
   logic              r_load_err;

   logic              w_clr;
   logic              w_acc;
   logic              w_fin;
   logic              w_pad_ok;
   logic              w_par_ok;
   logic              w_bad;
   logic              w_stage;
   logic              w_commit;
   logic              w_err;

   assign w_clr    = rst | clear;
   assign in_ready = !rst && (r_state == S_IDLE || r_state == S_LOAD);
   assign w_acc    = in_valid && in_ready;
   assign w_fin    = (r_cnt == LAST_CNT);
   // bits of the final chunk above the key width must be zero
   assign w_pad_ok = ((in_data >> HI_W) == '0);

`ifdef KEY_LOADER_PARITY_EN
   assign w_par_ok = (in_par == ^in_data);
`else
   assign w_par_ok = 1'b1;
`endif

   assign w_bad = (in_last && !w_fin)
                | (w_fin && !in_last)
                | (w_fin && !w_pad_ok)
                | !w_par_ok;

   always_ff @(posedge clk) begin
      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stage     = 1'b0;
      w_commit    = 1'b0;
      w_err       = 1'b0;
      if (w_clr) begin
         w_state_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE, S_LOAD: begin
               if (w_acc) begin
                  if (w_bad) begin
                     w_state_nxt = S_ERR;
                     w_err       = 1'b1;
                  end else if (w_fin) begin
                     w_state_nxt = S_DONE;
                     w_commit    = 1'b1;
                  end else begin
                     w_state_nxt = S_LOAD;
                     w_stage     = 1'b1;
                  end
               end
            end
            S_DONE, S_ERR: begin
               w_state_nxt = r_state;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_cnt       <= '0;
         r_shadow    <= '0;
         r_key       <= '0;
         r_key_valid <= 1'b0;
         r_load_err  <= 1'b0;
      end else begin
         if (w_stage) begin
            r_cnt <= r_cnt + 1'b1;
            for (int i = 0; i < NCHUNK - 1; i++) begin
               if (r_cnt == CNT_W'(i))
                  r_shadow[i*CHUNK_W +: CHUNK_W] <= in_data;
            end
         end
         if (w_commit) begin
            r_key       <= {in_data[HI_W-1:0], r_shadow};
            r_key_valid <= 1'b1;
            r_shadow    <= '0;
            r_cnt       <= '0;
         end
         // a rejected load leaves no trace of its chunks
         if (w_err) begin
            r_load_err <= 1'b1;
            r_shadow   <= '0;
            r_cnt      <= '0;
         end
      end
   end

   assign locking_key = r_key;
   assign key_valid   = r_key_valid;
   assign load_err    = r_load_err;

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: nominal, malformed, stall, clear and reset loads.
// Parity vectors run only when KEY_LOADER_PARITY_EN is defined.
module tb_key_loader;

   localparam int KEY_W   = 255;
   localparam int CHUNK_W = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [CHUNK_W-1:0] in_data;
   logic               in_last;
`ifdef KEY_LOADER_PARITY_EN
   logic               in_par;
`endif
   logic               clear;
   logic [KEY_W-1:0]   locking_key;
   logic               key_valid;
   logic               load_err;

   logic [KEY_W-1:0]   exp_key;
   logic [KEY_W-1:0]   held_key;
   int                 total = 0;
   int                 bad   = 0;

   always #5 clk = ~clk;

   key_loader #(.KEY_W(KEY_W), .CHUNK_W(CHUNK_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
`ifdef KEY_LOADER_PARITY_EN
      .in_par      (in_par),
`endif
      .clear       (clear),
      .locking_key (locking_key),
      .key_valid   (key_valid),
      .load_err    (load_err)
   );

   task automatic chk(input string tag,
                      input logic [KEY_W-1:0] obs,
                      input logic [KEY_W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [CHUNK_W-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
`ifdef KEY_LOADER_PARITY_EN
      in_par   = ^d;
`endif
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic load_nominal();
      for (int k = 0; k < 32; k++)
         send(CHUNK_W'(k), k == 31);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      clear    = 1'b0;
`ifdef KEY_LOADER_PARITY_EN
      in_par   = 1'b0;
`endif
      exp_key = '0;
      for (int k = 0; k < 31; k++)
         exp_key[k*8 +: 8] = 8'(k);
      exp_key[254:248] = 7'h1F;

      tick();
      tick();
      chk("rst_ready", in_ready, 0);
      chk("rst_key", locking_key, 0);
      chk("rst_kv", key_valid, 0);
      chk("rst_err", load_err, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", in_ready, 1);

      // nominal
      for (int k = 0; k < 31; k++)
         send(CHUNK_W'(k), 1'b0);
      chk("nom_kv_before", key_valid, 0);
      chk("nom_key_before", locking_key, 0);
      send(8'h1F, 1'b1);
      chk("nom_kv", key_valid, 1);
      chk("nom_ready", in_ready, 0);
      chk("nom_b0", locking_key[7:0], 8'h00);
      chk("nom_b1", locking_key[15:8], 8'h01);
      chk("nom_top", locking_key[254:248], 7'h1F);
      chk("nom_key", locking_key, exp_key);
      chk("nom_err", load_err, 0);

      // DONE ignores further traffic
      held_key = locking_key;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("done_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("done_hold", locking_key, held_key);
      chk("done_kv", key_valid, 1);

      pulse_clear();
      chk("clr_key", locking_key, 0);
      chk("clr_kv", key_valid, 0);
      chk("clr_ready", in_ready, 1);

      // early last on chunk 10
      for (int k = 0; k < 10; k++)
         send(CHUNK_W'(k), 1'b0);
      chk("early_err_before", load_err, 0);
      send(8'd10, 1'b1);
      chk("early_err", load_err, 1);
      chk("early_key", locking_key, 0);
      chk("early_ready", in_ready, 0);
      chk("early_kv", key_valid, 0);
      pulse_clear();
      chk("early_clr_err", load_err, 0);
      chk("early_clr_ready", in_ready, 1);

      // 32 chunks with no last
      for (int k = 0; k < 32; k++)
         send(CHUNK_W'(k), 1'b0);
      chk("nolast_err", load_err, 1);
      chk("nolast_key", locking_key, 0);
      chk("nolast_kv", key_valid, 0);
      pulse_clear();

      // pad bit set in final chunk
      for (int k = 0; k < 31; k++)
         send(CHUNK_W'(k), 1'b0);
      send(8'h80, 1'b1);
      chk("pad_err", load_err, 1);
      chk("pad_key", locking_key, 0);
      chk("pad_kv", key_valid, 0);
      pulse_clear();

      // gaps of 0..5 idle cycles
      for (int k = 0; k < 32; k++) begin
         send(CHUNK_W'(k), k == 31);
         repeat (k % 6) tick();
      end
      chk("gap_key", locking_key, exp_key);
      chk("gap_kv", key_valid, 1);
      pulse_clear();

      // clear coincident with chunk 20
      for (int k = 0; k < 20; k++)
         send(CHUNK_W'(k), 1'b0);
      clear = 1'b1;
      send(8'd20, 1'b0);
      clear = 1'b0;
      chk("clr20_key", locking_key, 0);
      chk("clr20_ready", in_ready, 1);
      chk("clr20_kv", key_valid, 0);
      load_nominal();
      chk("clr20_reload", locking_key, exp_key);
      pulse_clear();

      // reset mid-load
      for (int k = 0; k < 15; k++)
         send(CHUNK_W'(k), 1'b0);
      rst = 1'b1;
      tick();
      chk("rstmid_ready", in_ready, 0);
      chk("rstmid_key", locking_key, 0);
      chk("rstmid_kv", key_valid, 0);
      chk("rstmid_err", load_err, 0);
      rst = 1'b0;
      #1;
      chk("rstmid_ready_after", in_ready, 1);
      load_nominal();
      chk("rstmid_reload", locking_key, exp_key);
      pulse_clear();

`ifdef KEY_LOADER_PARITY_EN
      in_valid = 1'b1;
      in_data  = 8'h03;
      in_par   = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("par_bad_err", load_err, 1);
      chk("par_bad_ready", in_ready, 0);
      pulse_clear();
      in_valid = 1'b1;
      in_data  = 8'h03;
      in_par   = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("par_ok_err", load_err, 0);
      chk("par_ok_ready", in_ready, 1);
      pulse_clear();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
